// File: rtl/seq_chunk_adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the sequential chunked adder:
//   - state_e     : FSM states IDLE / RUN / DONE
//   - MODE_ADD/SUB: encodings of the 'sub' input
//   - WIDTH_DEF / CHUNK_DEF : default operand width and slice width
//   - ovf_calc()  : two's-complement overflow from the three sign bits
// No ports (package).
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int WIDTH_DEF = 32;
    localparam int CHUNK_DEF = 8;

    // Overflow occurs when both addends share a sign that the result does not.
    // b_msb must be the sign of the operand actually added (inverted for sub).
    function automatic logic ovf_calc(input logic a_msb,
                                      input logic b_msb,
                                      input logic z_msb);
        return (a_msb == b_msb) && (z_msb != a_msb);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_add.sv
// -----------------------------------------------------------------------------
// chunk_add
// Combinational CHUNK-bit adder with carry in and carry out.
// Ports:
//   a, b : CHUNK-bit addends
//   ci   : carry in
//   s    : CHUNK-bit sum
//   co   : carry out (bit CHUNK of the CHUNK+1-bit sum)
// -----------------------------------------------------------------------------
module chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] sum_w;

    always_comb begin
        sum_w = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
        s     = sum_w[CHUNK-1:0];
        co    = sum_w[CHUNK];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, carrying
// between slices in a register, with valid/ready on input and output.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (accepted only in IDLE)
//   a, b, cin, sub      : operands, carry-in (ignored for sub), mode
//   out_valid/out_ready : output handshake (result held in DONE)
//   z, cout, ovf        : result, MSB carry (1 = no borrow on sub), overflow
// -----------------------------------------------------------------------------
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("seq_chunk_adder: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;     // already inverted for subtraction
    logic [WIDTH-1:0]   z_q,     z_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;

    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK-1:0]   sum_slice;
    logic               sum_co;

    // Select the operand slice addressed by idx_q.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_slice = a_q[i*CHUNK +: CHUNK];
                b_slice = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a  (a_slice),
        .b  (b_slice),
        .ci (carry_q),
        .s  (sum_slice),
        .co (sum_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    idx_d   = '0;
                    z_d     = '0;
                    state_d = RUN;
                    // Subtraction is a + ~b + 1: the +1 rides in on the carry.
                    if (sub == MODE_SUB) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = b;
                        carry_d = cin;
                    end
                end
            end
            RUN: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        z_d[i*CHUNK +: CHUNK] = sum_slice;
                    end
                end
                carry_d = sum_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // The top slice's sum MSB is the result sign bit.
                    cout_d  = sum_co;
                    ovf_d   = ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1], sum_slice[CHUNK-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = z_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_adder
// Scoreboard bench: two DUTs (CHUNK=8 and CHUNK=32). Stimulus pushes the
// expected result into a per-DUT queue; monitors pop and compare whenever
// a result is handed over (out_valid && out_ready).
// -----------------------------------------------------------------------------
module tb_seq_chunk_adder;

    typedef struct packed {
        logic [31:0] z;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        iv0 = 1'b0, ir0, ov0, or0 = 1'b1, cin0 = 1'b0, sub0 = 1'b0, c0, o0;
    logic [31:0] a0 = '0, b0 = '0, z0;
    logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b1, cin1 = 1'b0, sub1 = 1'b0, c1, o1;
    logic [31:0] a1 = '0, b1 = '0, z1;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .out_valid(ov0), .out_ready(or0), .z(z0), .cout(c0), .ovf(o0)
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(ov1), .out_ready(or1), .z(z1), .cout(c1), .ovf(o1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mc, input logic ms);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] s;
        bb  = ms ? ~mb : mb;
        s   = {1'b0, ma} + {1'b0, bb} + {32'd0, (ms ? 1'b1 : mc)};
        e.z = s[31:0];
        e.c = s[32];
        e.o = (ma[31] == bb[31]) && (s[31] != ma[31]);
        return e;
    endfunction

    // Monitors: a result is consumed at the edge following a negedge where
    // out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (!reset && ov0 && or0) begin
            if (q0.size() == 0) begin
                chk("unexpected_out0", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("z0", z0, e.z);
                chk("cout0", {31'd0, c0}, {31'd0, e.c});
                chk("ovf0", {31'd0, o0}, {31'd0, e.o});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ov1 && or1) begin
            if (q1.size() == 0) begin
                chk("unexpected_out1", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("z1", z1, e.z);
                chk("cout1", {31'd0, c1}, {31'd0, e.c});
                chk("ovf1", {31'd0, o1}, {31'd0, e.o});
            end
        end
    end

    // Present one operation, wait for acceptance, then scramble the inputs
    // to show that post-accept changes are ignored.
    task automatic issue(input bit sel, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input logic is, input bit push, input exp_t e);
        int n;
        n = 0;
        if (!sel) begin
            a0 = ia; b0 = ib; cin0 = ic; sub0 = is; iv0 = 1'b1;
            while (!ir0 && n < 50) begin @(posedge clk); #1; n++; end
        end else begin
            a1 = ia; b1 = ib; cin1 = ic; sub1 = is; iv1 = 1'b1;
            while (!ir1 && n < 50) begin @(posedge clk); #1; n++; end
        end
        if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        if (push) begin
            if (!sel) q0.push_back(e);
            else      q1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!sel) begin
            iv0 = 1'b0; a0 = ~ia; b0 = ~ib; cin0 = ~ic; sub0 = ~is;
        end else begin
            iv1 = 1'b0; a1 = ~ia; b1 = ~ib; cin1 = ~ic; sub1 = ~is;
        end
    endtask

    // Count edges from acceptance until out_valid is seen.
    task automatic wait_result(input bit sel, input int lat, input string nm);
        int n;
        n = 0;
        while ((sel ? ov1 : ov0) !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk(nm, n, lat);
    endtask

    task automatic run_op(input bit sel, input logic [31:0] ia, input logic [31:0] ib,
                          input logic ic, input logic is, input exp_t e, input string nm);
        issue(sel, ia, ib, ic, is, 1'b1, e);
        wait_result(sel, sel ? 1 : 4, nm);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] hz;
        logic        hc, ho;
        logic [31:0] ra, rb;
        logic        rc;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready0", {31'd0, ir0}, 32'd1);
        chk("rst_out_valid0", {31'd0, ov0}, 32'd0);
        chk("rst_z0", z0, 32'd0);
        chk("rst_cout_ovf0", {30'd0, c0, o0}, 32'd0);
        chk("rst_in_ready1", {31'd0, ir1}, 32'd1);
        chk("rst_out_valid1", {31'd0, ov1}, 32'd0);

        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}, "lat_carry");
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}, "lat_ovf");
        run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}, "lat_borrow");
        run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1}, "lat_sub_ovf");

        // Backpressure: hold the result, poke in_valid, confirm nothing moves.
        or0 = 1'b0;
        issue(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, '{32'h2345_678A, 1'b0, 1'b0});
        wait_result(0, 4, "lat_bp");
        hz = z0; hc = c0; ho = o0;
        chk("bp_z_held_value", hz, 32'h2345_678A);
        for (int i = 0; i < 3; i++) begin
            a0 = 32'hDEAD_BEEF; b0 = 32'h0BAD_F00D; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1;
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, ir0}, 32'd0);
            chk("bp_out_valid", {31'd0, ov0}, 32'd1);
            chk("bp_z_stable", z0, hz);
            chk("bp_flags_stable", {30'd0, c0, o0}, {30'd0, hc, ho});
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", {31'd0, ir0}, 32'd1);
        chk("bp_release_out_valid", {31'd0, ov0}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_not_accepted", {30'd0, ov0, ir0}, 32'd1);

        // Reset mid-operation after two RUN cycles.
        issue(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 1'b0, '{32'd0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        chk("mid_run_busy", {31'd0, ir0}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_in_ready", {31'd0, ir0}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, ov0}, 32'd0);
        chk("mid_rst_z", z0, 32'd0);
        chk("mid_rst_flags", {30'd0, c0, o0}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst_no_result", {31'd0, ov0}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            run_op(0, ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0), "lat_rand0");
        end

        run_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}, "lat1_ovf");
        run_op(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}, "lat1_borrow");
        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            run_op(1, ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0), "lat_rand1");
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue0_drained", q0.size(), 32'd0);
        chk("queue1_drained", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
